// File: rtl/bus_arbiter.sv
//==============================================================================
// Module      : bus_arbiter
// Description : Shares one single-port memory bus between instruction fetch
//               (IF) and load/store (MEM). Data side has priority; a
//               starvation counter forces fetch in after STARVE_MAX
//               consecutive data grants while fetch waits.
//               Optional macro ARB_TIMEOUT_EN adds a bus-ack timeout that
//               pulses bus_err_o and completes the transfer with zero data.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_MAX     = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch side
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              stallreq_from_if_o,
    input  logic              flush_i,
    // load/store side
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              stallreq_from_mem_o,
    // SoC bus side
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_DONE_I = 3'd3,
        S_DONE_D = 3'd4
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state;
    logic [3:0]          starve_cnt;
    logic                drop;
    logic                mem_wins;
    logic                xfer_done;
    logic [DATA_W-1:0]   xfer_data;

    // Data wins unless fetch has already waited out STARVE_MAX data grants
    assign mem_wins = mem_req_i && !(if_req_i && (starve_cnt == STARVE_LIM));

    // Stall requests are gated by reset so ctrl never sees them during reset
    assign stallreq_from_if_o  = if_req_i  & ~if_ack_o  & ~rst;
    assign stallreq_from_mem_o = mem_req_i & ~mem_ack_o & ~rst;

`ifdef ARB_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tcnt;
    logic             timed_out;

    // A timed-out cycle completes on its own with zero data; late acks ignored
    assign xfer_done = timed_out | bus_ack_i;
    assign xfer_data = timed_out ? '0 : bus_rdata_i;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign xfer_done      = bus_ack_i;
    assign xfer_data      = bus_rdata_i;
    assign bus_err_o      = 1'b0;
`endif

    // Arbitration FSM with registered bus and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            drop        <= 1'b0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
`ifdef ARB_TIMEOUT_EN
            tcnt        <= '0;
            timed_out   <= 1'b0;
            bus_err_o   <= 1'b0;
`endif
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus_err_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // Count data grants only while fetch is actually waiting
                    if (!if_req_i) begin
                        starve_cnt <= '0;
                    end else if (mem_wins) begin
                        if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
                    end else begin
                        starve_cnt <= '0;
                    end

                    if (mem_wins) begin
                        state       <= S_BUSY_D;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_wdata_o <= mem_wdata_i;
                    end else if (if_req_i) begin
                        state       <= S_BUSY_I;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= if_addr_i;
                        bus_sel_o   <= 4'hF;
                        bus_wdata_o <= '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    tcnt      <= '0;
                    timed_out <= 1'b0;
`endif
                end

                S_BUSY_I, S_BUSY_D: begin
                    // A flushed fetch still finishes on the bus but is not delivered
                    if ((state == S_BUSY_I) && flush_i) drop <= 1'b1;

                    if (xfer_done) begin
                        bus_req_o <= 1'b0;
                        if (state == S_BUSY_I) begin
                            if_rdata_o <= xfer_data;
                            if_ack_o   <= !(drop || flush_i);
                            state      <= S_DONE_I;
                        end else begin
                            mem_rdata_o <= xfer_data;
                            mem_ack_o   <= 1'b1;
                            state       <= S_DONE_D;
                        end
`ifdef ARB_TIMEOUT_EN
                        timed_out <= 1'b0;
                    end else if (tcnt == TMO_LAST) begin
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                        timed_out <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TMO_W'(1);
`endif
                    end
                end

                S_DONE_I: begin
                    drop  <= 1'b0;
                    state <= S_IDLE;
                end

                S_DONE_D: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
//==============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter with a simple
//               bus responder that acks after a programmable wait count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        stallreq_from_if_o;
    logic        flush_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        stallreq_from_mem_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    int compared = 0;
    int mismatched = 0;

    // responder controls
    logic        ack_en;
    int          wait_states;
    logic [31:0] rdata_val;
    int          wcnt;

    bus_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .STARVE_MAX     (3),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_req_i            (if_req_i),
        .if_addr_i           (if_addr_i),
        .if_rdata_o          (if_rdata_o),
        .if_ack_o            (if_ack_o),
        .stallreq_from_if_o  (stallreq_from_if_o),
        .flush_i             (flush_i),
        .mem_req_i           (mem_req_i),
        .mem_we_i            (mem_we_i),
        .mem_addr_i          (mem_addr_i),
        .mem_sel_i           (mem_sel_i),
        .mem_wdata_i         (mem_wdata_i),
        .mem_rdata_o         (mem_rdata_o),
        .mem_ack_o           (mem_ack_o),
        .stallreq_from_mem_o (stallreq_from_mem_o),
        .bus_req_o           (bus_req_o),
        .bus_we_o            (bus_we_o),
        .bus_addr_o          (bus_addr_o),
        .bus_sel_o           (bus_sel_o),
        .bus_wdata_o         (bus_wdata_o),
        .bus_rdata_i         (bus_rdata_i),
        .bus_ack_i           (bus_ack_i),
        .bus_err_o           (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus slave: acks after wait_states idle cycles of bus_req_o
    always @(negedge clk) begin
        if (bus_req_o === 1'b1 && ack_en && !bus_ack_i) begin
            if (wcnt == wait_states) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rdata_val;
                wcnt        = 0;
            end else begin
                wcnt = wcnt + 1;
            end
        end else begin
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'hBAD0_BAD0;
            wcnt        = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared = compared + 1;
        assert (obs === exp) else begin
            mismatched = mismatched + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Holds both requests and checks the ack order against the expected pattern
    task automatic run_order(input int n);
        logic exp_i [8];
        int   k;
        int   cyc;
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        k   = 0;
        cyc = 0;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0040;
        mem_req_i = 1'b1;
        mem_we_i  = 1'b0;
        mem_addr_i = 32'h0000_0200;
        mem_sel_i = 4'hF;
        while (k < n && cyc < 200) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (if_ack_o || mem_ack_o) begin
                chk("order_no_dual_ack", {31'd0, if_ack_o & mem_ack_o}, 32'd0);
                chk($sformatf("order_%0d_is_fetch", k), {31'd0, if_ack_o}, {31'd0, exp_i[k]});
                k = k + 1;
            end
        end
        chk("order_count", k, n);
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("order_bus_idle", {31'd0, bus_req_o}, 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0; flush_i = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_wdata_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        ack_en = 1'b1; wait_states = 0; rdata_val = '0; wcnt = 0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        if_req_i = 1'b1;
        #1;
        chk("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_if_ack", {31'd0, if_ack_o}, 32'd0);
        chk("rst_mem_ack", {31'd0, mem_ack_o}, 32'd0);
        chk("rst_stall_if", {31'd0, stallreq_from_if_o}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
        if_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- fetch only, zero wait ----------------
        if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
        wait_states = 0; rdata_val = 32'h3401_1100;
        #1;
        chk("f_stall_before", {31'd0, stallreq_from_if_o}, 32'd1);
        @(negedge clk);
        chk("f_bus_req", {31'd0, bus_req_o}, 32'd1);
        chk("f_bus_addr", bus_addr_o, 32'h0000_0010);
        chk("f_bus_we", {31'd0, bus_we_o}, 32'd0);
        chk("f_bus_sel", {28'd0, bus_sel_o}, 32'hF);
        chk("f_ack_early", {31'd0, if_ack_o}, 32'd0);
        chk("f_stall_busy", {31'd0, stallreq_from_if_o}, 32'd1);
        @(negedge clk);
        chk("f_ack", {31'd0, if_ack_o}, 32'd1);
        chk("f_rdata", if_rdata_o, 32'h3401_1100);
        chk("f_stall_at_ack", {31'd0, stallreq_from_if_o}, 32'd0);
        chk("f_bus_req_fall", {31'd0, bus_req_o}, 32'd0);
        if_req_i = 1'b0;
        @(negedge clk);
        chk("f_ack_pulse", {31'd0, if_ack_o}, 32'd0);

        // ---------------- store, 2 wait states ----------------
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0100;
        mem_sel_i = 4'b0011; mem_wdata_i = 32'hDEAD_BEEF;
        wait_states = 2; rdata_val = 32'h5555_AAAA;
        @(negedge clk);
        n = 0;
        while (bus_req_o === 1'b1 && n < 20) begin
            chk("s_bus_we", {31'd0, bus_we_o}, 32'd1);
            chk("s_bus_addr", bus_addr_o, 32'h0000_0100);
            chk("s_bus_sel", {28'd0, bus_sel_o}, 32'h3);
            chk("s_bus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
            chk("s_stall", {31'd0, stallreq_from_mem_o}, 32'd1);
            n = n + 1;
            @(negedge clk);
        end
        chk("s_req_cycles", n, 3);
        chk("s_ack", {31'd0, mem_ack_o}, 32'd1);
        chk("s_stall_at_ack", {31'd0, stallreq_from_mem_o}, 32'd0);
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        @(negedge clk);
        chk("s_ack_pulse", {31'd0, mem_ack_o}, 32'd0);
        wait_states = 0;

        // ---------------- starvation: D,D,D,I,D,D,D,I ----------------
        run_order(8);

        // ---------------- flush during BUSY_I ----------------
        if_req_i = 1'b1; if_addr_i = 32'h0000_0020;
        wait_states = 2; rdata_val = 32'hCAFE_0001;
        @(negedge clk);
        chk("fl_bus_req", {31'd0, bus_req_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        cyc = 0;
        while (bus_req_o === 1'b1 && cyc < 20) begin
            chk("fl_no_ack_busy", {31'd0, if_ack_o}, 32'd0);
            @(negedge clk);
            cyc = cyc + 1;
        end
        chk("fl_busy_tail", cyc, 2);
        chk("fl_dropped_ack", {31'd0, if_ack_o}, 32'd0);
        chk("fl_stall_held", {31'd0, stallreq_from_if_o}, 32'd1);
        wait_states = 0; rdata_val = 32'h1234_5678;
        cyc = 0;
        while (!if_ack_o && cyc < 20) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        chk("fl_refetch_lat", cyc, 3);
        chk("fl_refetch_data", if_rdata_o, 32'h1234_5678);
        if_req_i = 1'b0;
        @(negedge clk);

        // ---------------- reset mid BUSY_D ----------------
        ack_en = 1'b0;
        if_req_i = 1'b1; mem_req_i = 1'b1; mem_addr_i = 32'h0000_0300; mem_sel_i = 4'hF;
        @(negedge clk);
        chk("r_busy_d", {31'd0, bus_req_o}, 32'd1);
        chk("r_busy_d_addr", bus_addr_o, 32'h0000_0300);
        #2;
        rst = 1'b1;
        #1;
        chk("r_bus_req_async", {31'd0, bus_req_o}, 32'd0);
        chk("r_mem_ack", {31'd0, mem_ack_o}, 32'd0);
        chk("r_if_ack", {31'd0, if_ack_o}, 32'd0);
        chk("r_stall_mem", {31'd0, stallreq_from_mem_o}, 32'd0);
        @(negedge clk);
        if_req_i = 1'b0; mem_req_i = 1'b0;
        rst = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("r_idle_bus", {31'd0, bus_req_o}, 32'd0);
        chk("r_idle_mem_ack", {31'd0, mem_ack_o}, 32'd0);
        // starve_cnt must restart from zero: three data grants before fetch
        run_order(4);

`ifdef ARB_TIMEOUT_EN
        // ---------------- bus-ack timeout ----------------
        ack_en = 1'b0;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0400;
        @(negedge clk);
        n = 0;
        while (bus_req_o === 1'b1 && n < 40) begin
            n = n + 1;
            @(negedge clk);
        end
        chk("t_busy_cycles", n, 8);
        chk("t_err", {31'd0, bus_err_o}, 32'd1);
        @(negedge clk);
        chk("t_err_pulse", {31'd0, bus_err_o}, 32'd0);
        chk("t_ack", {31'd0, mem_ack_o}, 32'd1);
        chk("t_rdata", mem_rdata_o, 32'h0);
        mem_req_i = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
`else
        chk("err_tied", {31'd0, bus_err_o}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
